// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the 8N1 UART transceiver: TX/RX state encodings,
// frame constants and the half-bit sampling offset helper.
// ---------------------------------------------------------------------------
package uart_pkg;

   // Transmit FSM states
   typedef enum logic [1:0] {
      TXS_IDLE  = 2'd0,
      TXS_START = 2'd1,
      TXS_DATA  = 2'd2,
      TXS_STOP  = 2'd3
   } tx_state_e;

   // Receive FSM states
   typedef enum logic [1:0] {
      RXS_IDLE  = 2'd0,
      RXS_START = 2'd1,
      RXS_DATA  = 2'd2,
      RXS_STOP  = 2'd3
   } rx_state_e;

   localparam int   DATA_BITS = 8;
   localparam logic LINE_IDLE = 1'b1;

   // Offset from the start-bit edge to the start-bit centre (integer half).
   function automatic logic [15:0] half_bit_count(input logic [15:0] clks_per_bit);
      return {1'b0, clks_per_bit[15:1]};
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
// Serial receive engine: 2-flop synchronizer on rxd, start-bit validation at
// the half-bit point, centre sampling of 8 data bits (LSB first) and stop bit.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   rxd        asynchronous serial input, idle high
//   rx_byte    assembled byte; valid while byte_valid is high
//   byte_valid one-cycle strobe: stop bit sampled high, rx_byte complete
//   frame_err  one-cycle strobe: stop bit sampled low, byte discarded
// ---------------------------------------------------------------------------
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_BIT = half_bit_count(16'(CLKS_PER_BIT));

   logic        rxd_meta_q;
   logic        rxd_sync_q;
   rx_state_e   state_q,     state_d;
   logic [15:0] cnt_q,       cnt_d;
   logic [2:0]  bit_q,       bit_d;
   logic [7:0]  shift_q,     shift_d;
   logic        wait_high_q, wait_high_d;
   logic        byte_valid_s;
   logic        frame_err_s;

   // Two-flop synchronizer for the asynchronous serial line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_meta_q <= LINE_IDLE;
         rxd_sync_q <= LINE_IDLE;
      end else begin
         rxd_meta_q <= rxd;
         rxd_sync_q <= rxd_meta_q;
      end
   end

   // Receive FSM state, baud counter, bit counter and shift register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RXS_IDLE;
         cnt_q       <= 16'd0;
         bit_q       <= 3'd0;
         shift_q     <= 8'd0;
         wait_high_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         wait_high_q <= wait_high_d;
      end
   end

   // Next-state and sampling decisions, all on the synchronized line
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      wait_high_d  = wait_high_q;
      byte_valid_s = 1'b0;
      frame_err_s  = 1'b0;
      case (state_q)
         RXS_IDLE: begin
            cnt_d = 16'd0;
            bit_d = 3'd0;
            if (wait_high_q) begin
               // After a framing error, re-arm only once the line is idle again
               if (rxd_sync_q == LINE_IDLE) begin
                  wait_high_d = 1'b0;
               end else begin
                  wait_high_d = 1'b1;
               end
            end else if (rxd_sync_q != LINE_IDLE) begin
               state_d = RXS_START;
            end else begin
               state_d = RXS_IDLE;
            end
         end
         RXS_START: begin
            if (cnt_q == HALF_BIT) begin
               cnt_d = 16'd0;
               // Line back high at the start-bit centre: a glitch, drop it silently
               if (rxd_sync_q == LINE_IDLE) begin
                  state_d = RXS_IDLE;
               end else begin
                  state_d = RXS_DATA;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RXS_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = 16'd0;
               shift_d = {rxd_sync_q, shift_q[7:1]};
               if (bit_q == 3'(DATA_BITS - 1)) begin
                  bit_d   = 3'd0;
                  state_d = RXS_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RXS_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = 16'd0;
               state_d = RXS_IDLE;
               if (rxd_sync_q == LINE_IDLE) begin
                  byte_valid_s = 1'b1;
               end else begin
                  frame_err_s = 1'b1;
                  wait_high_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = RXS_IDLE;
            cnt_d   = 16'd0;
            bit_d   = 3'd0;
         end
      endcase
   end

   assign rx_byte    = shift_q;
   assign byte_valid = byte_valid_s;
   assign frame_err  = frame_err_s;

endmodule

// File: rtl/uart_transceiver.sv
// ---------------------------------------------------------------------------
// uart_transceiver
// Byte-wide 8N1 UART (1 start, 8 data LSB first, 1 stop, no parity) between
// the memory-mapped peripheral registers and the board serial pins.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   TX_DATA      byte to send, latched when a frame starts
//   TX_EN        transmit request level; a 0->1 transition starts a frame
//   TX_STATUS    1 = transmitter idle and ready
//   RX_DATA      last received byte
//   RX_EFF       1 = RX_DATA holds an unread byte
//   RX_READ      read strobe, clears RX_EFF
//   rxd / txd    serial line in / out, idle high
//   rx_overrun   one-cycle pulse: unread byte overwritten
//   rx_frame_err one-cycle pulse: stop bit low, byte discarded
// ---------------------------------------------------------------------------
module uart_transceiver
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] TX_DATA,
   input  logic       TX_EN,
   output logic       TX_STATUS,
   output logic [7:0] RX_DATA,
   output logic       RX_EFF,
   input  logic       RX_READ,
   input  logic       rxd,
   output logic       txd,
   output logic       rx_overrun,
   output logic       rx_frame_err
);

   localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

   // Transmit path state
   logic        tx_en_q;
   tx_state_e   tx_state_q,  tx_state_d;
   logic [15:0] tx_cnt_q,    tx_cnt_d;
   logic [2:0]  tx_bit_q,    tx_bit_d;
   logic [7:0]  tx_shift_q,  tx_shift_d;
   logic        txd_q,       txd_d;
   logic        tx_status_q, tx_status_d;
   logic        tx_start_s;

   // Receive holding register state
   logic [7:0]  rx_data_q,      rx_data_d;
   logic        rx_eff_q,       rx_eff_d;
   logic        rx_overrun_q,   rx_overrun_d;
   logic        rx_frame_err_q, rx_frame_err_d;
   logic [7:0]  rx_byte_s;
   logic        byte_valid_s;
   logic        frame_err_s;

   uart_rx_core #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx_core (
      .clk        (clk),
      .rst_n      (reset),
      .rxd        (rxd),
      .rx_byte    (rx_byte_s),
      .byte_valid (byte_valid_s),
      .frame_err  (frame_err_s)
   );

   // Transmit FSM registers and previous TX_EN for edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_en_q     <= 1'b0;
         tx_state_q  <= TXS_IDLE;
         tx_cnt_q    <= 16'd0;
         tx_bit_q    <= 3'd0;
         tx_shift_q  <= 8'd0;
         txd_q       <= LINE_IDLE;
         tx_status_q <= 1'b1;
      end else begin
         tx_en_q     <= TX_EN;
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_bit_q    <= tx_bit_d;
         tx_shift_q  <= tx_shift_d;
         txd_q       <= txd_d;
         tx_status_q <= tx_status_d;
      end
   end

   // Transmit FSM next state; txd and TX_STATUS are computed one cycle ahead
   always_comb begin
      tx_start_s  = TX_EN & ~tx_en_q;
      tx_state_d  = tx_state_q;
      tx_cnt_d    = tx_cnt_q;
      tx_bit_d    = tx_bit_q;
      tx_shift_d  = tx_shift_q;
      txd_d       = txd_q;
      tx_status_d = tx_status_q;
      case (tx_state_q)
         TXS_IDLE: begin
            tx_cnt_d    = 16'd0;
            tx_bit_d    = 3'd0;
            txd_d       = LINE_IDLE;
            tx_status_d = 1'b1;
            if (tx_start_s) begin
               tx_shift_d  = TX_DATA;
               tx_state_d  = TXS_START;
               txd_d       = 1'b0;
               tx_status_d = 1'b0;
            end else begin
               tx_state_d = TXS_IDLE;
            end
         end
         TXS_START: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = 16'd0;
               tx_state_d = TXS_DATA;
               txd_d      = tx_shift_q[0];
            end else begin
               tx_cnt_d = tx_cnt_q + 16'd1;
            end
         end
         TXS_DATA: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d = 16'd0;
               if (tx_bit_q == 3'(DATA_BITS - 1)) begin
                  tx_bit_d   = 3'd0;
                  tx_state_d = TXS_STOP;
                  txd_d      = LINE_IDLE;
               end else begin
                  // Shift first, so the next bit out is always bit 0 of the register
                  tx_bit_d   = tx_bit_q + 3'd1;
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  txd_d      = tx_shift_q[1];
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 16'd1;
            end
         end
         TXS_STOP: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d    = 16'd0;
               tx_state_d  = TXS_IDLE;
               txd_d       = LINE_IDLE;
               tx_status_d = 1'b1;
            end else begin
               tx_cnt_d = tx_cnt_q + 16'd1;
            end
         end
         default: begin
            tx_state_d  = TXS_IDLE;
            tx_cnt_d    = 16'd0;
            tx_bit_d    = 3'd0;
            txd_d       = LINE_IDLE;
            tx_status_d = 1'b1;
         end
      endcase
   end

   // Receive holding register and status pulse registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_data_q      <= 8'd0;
         rx_eff_q       <= 1'b0;
         rx_overrun_q   <= 1'b0;
         rx_frame_err_q <= 1'b0;
      end else begin
         rx_data_q      <= rx_data_d;
         rx_eff_q       <= rx_eff_d;
         rx_overrun_q   <= rx_overrun_d;
         rx_frame_err_q <= rx_frame_err_d;
      end
   end

   // A completed byte takes priority over a coincident read strobe
   always_comb begin
      rx_data_d      = rx_data_q;
      rx_eff_d       = rx_eff_q;
      rx_overrun_d   = 1'b0;
      rx_frame_err_d = frame_err_s;
      if (byte_valid_s) begin
         rx_data_d    = rx_byte_s;
         rx_eff_d     = 1'b1;
         rx_overrun_d = rx_eff_q & ~RX_READ;
      end else if (RX_READ) begin
         rx_eff_d = 1'b0;
      end else begin
         rx_eff_d = rx_eff_q;
      end
   end

   assign txd          = txd_q;
   assign TX_STATUS    = tx_status_q;
   assign RX_DATA      = rx_data_q;
   assign RX_EFF       = rx_eff_q;
   assign rx_overrun   = rx_overrun_q;
   assign rx_frame_err = rx_frame_err_q;

endmodule
